llc_snoop_responder: RTL and testbench

// - Downstream of the LLC snooped-read lookup. Takes one lookup verdict per snoop (NOHIT/HIT/HITM) plus the snooped address.
// - Drives the HIT/HITM snoop-result strobes onto the bus.
// - On HITM: fetches the modified line from L1 (GETLINE), buffers it, and writes it back on the bus as a burst.
// - Turns the behavioural PutSnoopResult/MessageToCache side effects into cycle-accurate RTL handshakes.

---
 rtl/llc_snoop_responder_pkg.sv | 33 +++
 rtl/llc_line_buffer.sv | 27 ++
 rtl/llc_snoop_responder.sv | 160 ++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_snoop_responder_pkg.sv
// Shared snoop-responder types: lookup verdict encoding, responder FSM states,
// and the line/beat geometry helpers used to size counters and the line buffer.
package cache_define;

  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_BUS_W      = 64;

  function automatic int calc_beats(input int line_bytes, input int bus_w);
    return (line_bytes * 8) / bus_w;
  endfunction

  localparam int BEATS  = calc_beats(DEF_LINE_BYTES, DEF_BUS_W);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFFSET = $clog2(DEF_LINE_BYTES);

  typedef enum logic [1:0] {
    SNP_HIT   = 2'b00,
    SNP_HITM  = 2'b01,
    SNP_NOHIT = 2'b10
  } snoop_result_t;

  // Code 11 is not a legal verdict; it is flagged and otherwise treated as NOHIT.
  localparam logic [1:0] SNP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESULT,
    ST_GETLINE,
    ST_FILL,
    ST_WB
  } resp_state_t;

endpackage

// File: rtl/llc_line_buffer.sv
// One-line staging buffer: written beat-by-beat while L1 returns the line,
// read combinationally by the writeback burst.
module llc_line_buffer #(
  parameter int BEATS = 8,
  parameter int BUS_W = 64,
  parameter int AW    = $clog2(BEATS)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [BUS_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [BUS_W-1:0] o_rdata
);

  // Contents are only meaningful after a complete fill, so no reset is needed.
  logic [BUS_W-1:0] r_mem [BEATS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/llc_snoop_responder.sv
// Snoop responder: strobes HIT/HITM for each lookup verdict and, on HITM,
// pulls the dirty line from L1 and writes it back on the bus as one burst.
module llc_snoop_responder
  import cache_define::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int BUS_W      = 64,
  parameter int L1_TMO     = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_snp_valid,
  output logic              o_snp_ready,
  input  logic [ADDR_W-1:0] i_snp_addr,
  input  logic [1:0]        i_snp_result,
  output logic              o_bus_hit,
  output logic              o_bus_hitm,
  output logic              o_l1_req,
  output logic [ADDR_W-1:0] o_l1_addr,
  input  logic              i_l1_ack,
  input  logic              i_l1_dvalid,
  input  logic [BUS_W-1:0]  i_l1_data,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [BUS_W-1:0]  o_wb_data,
  output logic              o_wb_last,
  output logic              o_err
);

  localparam int L_BEATS  = calc_beats(LINE_BYTES, BUS_W);
  localparam int L_BEAT_W = $clog2(L_BEATS);
  localparam int L_OFFSET = $clog2(LINE_BYTES);
  localparam int L_TMO_W  = $clog2(L1_TMO + 1);

  localparam logic [L_BEAT_W-1:0] LAST_BEAT = L_BEAT_W'(L_BEATS - 1);
  localparam logic [L_TMO_W-1:0]  TMO_LAST  = L_TMO_W'(L1_TMO - 1);
  localparam logic [ADDR_W-1:0]   LINE_MASK = {{(ADDR_W-L_OFFSET){1'b1}}, {L_OFFSET{1'b0}}};

  resp_state_t         r_state;
  resp_state_t         w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_result;
  logic [L_BEAT_W-1:0] r_fill_cnt;
  logic [L_BEAT_W-1:0] r_wb_cnt;
  logic [L_TMO_W-1:0]  r_tmo;

  logic                w_accept;
  logic                w_fill_we;
  logic                w_wb_fire;
  logic                w_tmo_hit;
  logic [ADDR_W-1:0]   w_line_addr;
  logic [BUS_W-1:0]    w_rd_data;

  assign w_accept    = i_snp_valid & (r_state == ST_IDLE);
  assign w_fill_we   = (r_state == ST_FILL) & i_l1_dvalid;
  assign w_wb_fire   = (r_state == ST_WB) & i_wb_ready;
  // The timeout only guards the wait for the first beat; once data flows L1 cannot stall.
  assign w_tmo_hit   = (r_state == ST_FILL) & ~i_l1_dvalid & (r_fill_cnt == '0) & (r_tmo == TMO_LAST);
  assign w_line_addr = r_addr & LINE_MASK;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_snp_valid) w_next = ST_RESULT;
      ST_RESULT:  w_next = (r_result == SNP_HITM) ? ST_GETLINE : ST_IDLE;
      ST_GETLINE: if (i_l1_ack) w_next = ST_FILL;
      ST_FILL: begin
        if (w_fill_we && (r_fill_cnt == LAST_BEAT)) begin
          w_next = ST_WB;
        end else if (w_tmo_hit) begin
          w_next = ST_IDLE;
        end
      end
      ST_WB:      if (w_wb_fire && (r_wb_cnt == LAST_BEAT)) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_snp_ready = (r_state == ST_IDLE);
    o_bus_hit   = 1'b0;
    o_bus_hitm  = 1'b0;
    o_l1_req    = 1'b0;
    o_l1_addr   = '0;
    o_wb_valid  = 1'b0;
    o_wb_addr   = '0;
    o_wb_data   = '0;
    o_wb_last   = 1'b0;
    o_err       = w_tmo_hit;
    case (r_state)
      ST_RESULT: begin
        o_bus_hit  = (r_result == SNP_HIT);
        o_bus_hitm = (r_result == SNP_HITM);
        o_err      = (r_result == SNP_RSVD);
      end
      ST_GETLINE: begin
        o_l1_req  = 1'b1;
        o_l1_addr = w_line_addr;
      end
      ST_WB: begin
        o_wb_valid = 1'b1;
        o_wb_addr  = w_line_addr;
        o_wb_data  = w_rd_data;
        o_wb_last  = (r_wb_cnt == LAST_BEAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_result   <= '0;
      r_fill_cnt <= '0;
      r_wb_cnt   <= '0;
      r_tmo      <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_snp_addr;
        r_result <= i_snp_result;
      end
      if (r_state == ST_GETLINE) begin
        r_tmo <= '0;
      end else if ((r_state == ST_FILL) && (r_fill_cnt == '0) && !i_l1_dvalid) begin
        r_tmo <= r_tmo + 1'b1;
      end
      // Both counters wrap to 0 naturally after the last beat of a burst.
      if (w_fill_we) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_wb_fire) begin
        r_wb_cnt <= r_wb_cnt + 1'b1;
      end
    end
  end

  llc_line_buffer #(
    .BEATS (L_BEATS),
    .BUS_W (BUS_W),
    .AW    (L_BEAT_W)
  ) u_line_buffer (
    .i_clk   (i_clk),
    .i_we    (w_fill_we),
    .i_waddr (r_fill_cnt),
    .i_wdata (i_l1_data),
    .i_raddr (r_wb_cnt),
    .o_rdata (w_rd_data)
  );

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed bench for llc_snoop_responder: verdict strobes, HITM fill and writeback
// burst (scoreboarded), stalled writeback, L1 timeout, mid-burst reset, reserved code.
module tb_llc_snoop_responder;

  localparam int ADDR_W = 32;
  localparam int BUS_W  = 64;
  localparam int TMO    = 255;
  localparam int NBEATS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  data;
    logic              last;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              snp_valid = 1'b0;
  logic              snp_ready;
  logic [ADDR_W-1:0] snp_addr = '0;
  logic [1:0]        snp_result = 2'b10;
  logic              bus_hit, bus_hitm;
  logic              l1_req;
  logic [ADDR_W-1:0] l1_addr;
  logic              l1_ack = 1'b0;
  logic              l1_dvalid = 1'b0;
  logic [BUS_W-1:0]  l1_data = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [ADDR_W-1:0] wb_addr;
  logic [BUS_W-1:0]  wb_data;
  logic              wb_last;
  logic              err;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int hitm_cnt = 0;
  int wbv_cnt = 0;
  wb_exp_t exp_q[$];
  logic stall_pend = 1'b0;
  logic [BUS_W-1:0] held = '0;

  always #5 clk = ~clk;

  llc_snoop_responder #(
    .ADDR_W(ADDR_W), .LINE_BYTES(64), .BUS_W(BUS_W), .L1_TMO(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_snp_valid(snp_valid), .o_snp_ready(snp_ready),
    .i_snp_addr(snp_addr), .i_snp_result(snp_result),
    .o_bus_hit(bus_hit), .o_bus_hitm(bus_hitm),
    .o_l1_req(l1_req), .o_l1_addr(l1_addr), .i_l1_ack(l1_ack),
    .i_l1_dvalid(l1_dvalid), .i_l1_data(l1_data),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_addr(wb_addr),
    .o_wb_data(wb_data), .o_wb_last(wb_last), .o_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a verdict; returns one cycle after acceptance (DUT in RESULT).
  task automatic send(input logic [1:0] res, input logic [ADDR_W-1:0] addr);
    snp_valid  = 1'b1;
    snp_result = res;
    snp_addr   = addr;
    tick();
    snp_valid  = 1'b0;
  endtask

  task automatic push_line(input logic [ADDR_W-1:0] laddr, input logic [BUS_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: laddr, data: base + BUS_W'(i), last: (i == NBEATS-1)});
    end
  endtask

  // HITM verdict through GETLINE handshake; returns in the first FILL cycle.
  task automatic hitm_to_fill(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] laddr);
    send(2'b01, addr);
    chk("hitm_strobe", bus_hitm, 1'b1);
    chk("hitm_no_hit", bus_hit, 1'b0);
    tick();
    chk("getline_req", l1_req, 1'b1);
    chk("getline_addr", l1_addr, laddr);
    tick();
    chk("getline_req_held", l1_req, 1'b1);
    l1_ack = 1'b1;
    tick();
    l1_ack = 1'b0;
    chk("getline_req_drop", l1_req, 1'b0);
  endtask

  task automatic fill(input logic [BUS_W-1:0] base);
    for (int i = 0; i < NBEATS; i++) begin
      l1_dvalid = 1'b1;
      l1_data   = base + BUS_W'(i);
      tick();
    end
    l1_dvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wb_valid) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, (n < 100), 1'b1);
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wb_exp_t e;
    if (!rst) begin
      if (bus_hit) hit_cnt++;
      if (bus_hitm) hitm_cnt++;
      if (bus_hit || bus_hitm) chk("strobe_exclusive", bus_hit & bus_hitm, 1'b0);
      if (wb_valid) wbv_cnt++;
      if (wb_valid && stall_pend) chk("wb_hold_data", wb_data, held);
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_data", wb_data, e.data);
          chk("wb_last", wb_last, e.last);
        end
      end
      stall_pend = wb_valid && !wb_ready;
      held       = wb_data;
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, n, w0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_snp_ready", snp_ready, 1'b1);
    chk("rst_bus_hit", bus_hit, 1'b0);
    chk("rst_l1_req", l1_req, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // HIT at 0x1040
    send(2'b00, 32'h0000_1040);
    chk("hit_strobe", bus_hit, 1'b1);
    chk("hit_no_hitm", bus_hitm, 1'b0);
    chk("hit_ready_low", snp_ready, 1'b0);
    chk("hit_no_req", l1_req, 1'b0);
    chk("hit_no_err", err, 1'b0);
    tick();
    chk("hit_pulse_end", bus_hit, 1'b0);
    chk("hit_ready_back", snp_ready, 1'b1);
    chk("hit_no_wb", wb_valid, 1'b0);

    // NOHIT immediately followed by HIT
    h0 = hit_cnt;
    snp_valid = 1'b1; snp_result = 2'b10; snp_addr = 32'h0000_2000;
    tick();
    chk("nohit_no_hit", bus_hit, 1'b0);
    chk("nohit_no_hitm", bus_hitm, 1'b0);
    chk("nohit_no_err", err, 1'b0);
    chk("nohit_ready_low", snp_ready, 1'b0);
    snp_result = 2'b00;
    tick();
    chk("b2b_ready", snp_ready, 1'b1);
    tick();
    snp_valid = 1'b0;
    chk("b2b_hit", bus_hit, 1'b1);
    tick();
    chk("b2b_hit_count", hit_cnt - h0, 1);

    // HITM with full-rate writeback
    wb_ready = 1'b1;
    w0 = wbv_cnt;
    hitm_to_fill(32'h0000_3048, 32'h0000_3040);
    push_line(32'h0000_3040, 64'hA0, NBEATS);
    fill(64'hA0);
    chk("wb_start", wb_valid, 1'b1);
    drain("hitm_drain");
    chk("hitm_wb_cycles", wbv_cnt - w0, NBEATS);
    chk("hitm_idle", snp_ready, 1'b1);

    // HITM with wb_ready toggling
    wb_ready = 1'b0;
    hitm_to_fill(32'h0000_3100, 32'h0000_3100);
    push_line(32'h0000_3100, 64'hB0, NBEATS);
    fill(64'hB0);
    w0 = wbv_cnt;
    n = 0;
    while (wb_valid && n < 40) begin
      tick();
      wb_ready = ~wb_ready;
      n++;
    end
    chk("stall_wb_cycles", wbv_cnt - w0, 16);
    chk("stall_q_empty", exp_q.size(), 0);

    // HITM with L1 silent after ack
    w0 = wbv_cnt;
    hitm_to_fill(32'h0000_4000, 32'h0000_4000);
    n = 0;
    while (!err && n < TMO + 10) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, TMO - 1);
    tick();
    chk("tmo_err_pulse", err, 1'b0);
    chk("tmo_idle", snp_ready, 1'b1);
    chk("tmo_no_wb", wbv_cnt - w0, 0);

    // Reset after 3 writeback beats
    wb_ready = 1'b1;
    hitm_to_fill(32'h0000_5000, 32'h0000_5000);
    push_line(32'h0000_5000, 64'hC0, 3);
    fill(64'hC0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wb_valid", wb_valid, 1'b0);
    chk("arst_wb_data", wb_data, 64'h0);
    chk("arst_wb_last", wb_last, 1'b0);
    chk("arst_snp_ready", snp_ready, 1'b1);
    chk("arst_beats_seen", exp_q.size(), 0);
    tick();
    rst = 1'b0;
    tick();
    send(2'b00, 32'h0000_6000);
    chk("post_rst_hit", bus_hit, 1'b1);
    chk("post_rst_no_req", l1_req, 1'b0);
    tick();
    chk("post_rst_wb_idle", wb_valid, 1'b0);

    // Reserved result code
    send(2'b11, 32'h0000_7000);
    chk("rsvd_err", err, 1'b1);
    chk("rsvd_no_hit", bus_hit, 1'b0);
    chk("rsvd_no_hitm", bus_hitm, 1'b0);
    tick();
    chk("rsvd_err_pulse", err, 1'b0);
    chk("rsvd_idle", snp_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
